// File: rtl/ps2_ascii_kbd.sv
// ---------------------------------------------------------------------------
// ps2_ascii_kbd
//
// PS/2 keyboard front end for the text-screen memory block. It receives
// 11-bit PS/2 frames, decodes scan-code set 2 make/break/extended
// sequences, tracks Shift and Caps Lock, and translates the last make
// code to ASCII. `pressing` and `ascii_write` form a held-key level. The
// screen memory applies its own repeat-rate throttle.
//
// Parameters:
//   TIMEOUT_CYCLES - idle clk cycles after the last PS/2 falling edge
//                    before a partially received frame is discarded
//   SYNC_STAGES    - synchronizer depth on ps2_clk / ps2_data (2..4)
//
// Ports:
//   clk          in   system clock
//   clrn         in   asynchronous active-low reset
//   ps2_clk      in   raw PS/2 clock
//   ps2_data     in   raw PS/2 data
//   pressing     out  high while the last mapped key is held
//   ascii_write  out  ASCII of the last mapped make code
//   scan_code    out  last accepted make code, without prefix
//   shift_o      out  left or right Shift held
//   caps_o       out  Caps Lock state
//   key_count    out  count of new (non-repeat) mapped presses, wraps
//   frame_err    out  one-cycle pulse on a rejected frame
//
// Optional feature macro: PS2_KBD_NUMPAD_EN
//   When defined, keypad digits/operators are translated, and the
//   extended keypad Enter (E0 5A) and keypad '/' (E0 4A) act as keys.
// ---------------------------------------------------------------------------
module ps2_ascii_kbd #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       pressing,
    output logic [7:0] ascii_write,
    output logic [7:0] scan_code,
    output logic       shift_o,
    output logic       caps_o,
    output logic [7:0] key_count,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        NORM,
        BRK,
        EXT,
        EXT_BRK
    } dec_state_t;

    // -----------------------------------------------------------------------
    // Scan-code set 2 to ASCII. Returns 00 for unmapped codes. Letters
    // follow shift XOR caps; symbols follow shift only.
    // -----------------------------------------------------------------------
    function automatic logic [7:0] xlate(input logic [7:0] code,
                                         input logic       sh,
                                         input logic       cp);
        logic [7:0] r;
        r = 8'h00;
        case (code)
            8'h1C: r = 8'h61; 8'h32: r = 8'h62; 8'h21: r = 8'h63;
            8'h23: r = 8'h64; 8'h24: r = 8'h65; 8'h2B: r = 8'h66;
            8'h34: r = 8'h67; 8'h33: r = 8'h68; 8'h43: r = 8'h69;
            8'h3B: r = 8'h6A; 8'h42: r = 8'h6B; 8'h4B: r = 8'h6C;
            8'h3A: r = 8'h6D; 8'h31: r = 8'h6E; 8'h44: r = 8'h6F;
            8'h4D: r = 8'h70; 8'h15: r = 8'h71; 8'h2D: r = 8'h72;
            8'h1B: r = 8'h73; 8'h2C: r = 8'h74; 8'h3C: r = 8'h75;
            8'h2A: r = 8'h76; 8'h1D: r = 8'h77; 8'h22: r = 8'h78;
            8'h35: r = 8'h79; 8'h1A: r = 8'h7A;
            8'h16: r = sh ? 8'h21 : 8'h31;
            8'h1E: r = sh ? 8'h40 : 8'h32;
            8'h26: r = sh ? 8'h23 : 8'h33;
            8'h25: r = sh ? 8'h24 : 8'h34;
            8'h2E: r = sh ? 8'h25 : 8'h35;
            8'h36: r = sh ? 8'h5E : 8'h36;
            8'h3D: r = sh ? 8'h26 : 8'h37;
            8'h3E: r = sh ? 8'h2A : 8'h38;
            8'h46: r = sh ? 8'h28 : 8'h39;
            8'h45: r = sh ? 8'h29 : 8'h30;
            8'h4E: r = sh ? 8'h5F : 8'h2D;
            8'h55: r = sh ? 8'h2B : 8'h3D;
            8'h54: r = sh ? 8'h7B : 8'h5B;
            8'h5B: r = sh ? 8'h7D : 8'h5D;
            8'h5D: r = sh ? 8'h7C : 8'h5C;
            8'h4C: r = sh ? 8'h3A : 8'h3B;
            8'h52: r = sh ? 8'h22 : 8'h27;
            8'h41: r = sh ? 8'h3C : 8'h2C;
            8'h49: r = sh ? 8'h3E : 8'h2E;
            8'h4A: r = sh ? 8'h3F : 8'h2F;
            8'h0E: r = sh ? 8'h7E : 8'h60;
            8'h29: r = 8'h20;
            8'h5A: r = 8'h0D;
            8'h66: r = 8'h08;
            8'h0D: r = 8'h09;
`ifdef PS2_KBD_NUMPAD_EN
            8'h70: r = 8'h30; 8'h69: r = 8'h31; 8'h72: r = 8'h32;
            8'h7A: r = 8'h33; 8'h6B: r = 8'h34; 8'h73: r = 8'h35;
            8'h74: r = 8'h36; 8'h6C: r = 8'h37; 8'h75: r = 8'h38;
            8'h7D: r = 8'h39; 8'h71: r = 8'h2E; 8'h79: r = 8'h2B;
            8'h7B: r = 8'h2D; 8'h7C: r = 8'h2A;
`endif
            default: r = 8'h00;
        endcase
        // Only the a..z range is case-folded; shifted symbols lie outside it.
        if (r >= 8'h61 && r <= 8'h7A && (sh ^ cp)) begin
            r = r - 8'h20;
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Synchronizers and falling-edge detector
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   ps2_clk_s, ps2_data_s, fall;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~ps2_clk_s;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = ps2_clk_s;
    end

    // -----------------------------------------------------------------------
    // Frame receiver and idle timeout
    // -----------------------------------------------------------------------
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          strobe_q, strobe_d;
    logic [7:0]    byte_q, byte_d;
    logic          err_q, err_d;
    logic [10:0]   frame_w;

    // frame_w is the frame as it looks once the bit on this edge lands:
    // [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign frame_w = {ps2_data_s, shift_q};

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        strobe_d  = 1'b0;
        byte_d    = byte_q;
        err_d     = 1'b0;
        if (fall) begin
            shift_d = frame_w[10:1];
            tmo_d   = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (!frame_w[0] && frame_w[10] && (^frame_w[9:1])) begin
                    strobe_d = 1'b1;
                    byte_d   = frame_w[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            if (tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + TW'(1);
            end
            if (bit_cnt_q != 4'd0 && tmo_q == TMO_MAX) begin
                bit_cnt_d = 4'd0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Decoder: one byte per strobe, make/break/extended handling
    // -----------------------------------------------------------------------
    dec_state_t state_q, state_d;
    logic       lshift_q, lshift_d;
    logic       rshift_q, rshift_d;
    logic       caps_q, caps_d;
    logic [7:0] last_make_q, last_make_d;
    logic       pressing_q, pressing_d;
    logic [7:0] ascii_q, ascii_d;
    logic [7:0] scan_q, scan_d;
    logic [7:0] count_q, count_d;
    logic       make_en;
    logic [7:0] make_ascii;

    always_comb begin
        state_d     = state_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_d      = caps_q;
        last_make_d = last_make_q;
        pressing_d  = pressing_q;
        ascii_d     = ascii_q;
        scan_d      = scan_q;
        count_d     = count_q;
        make_en     = 1'b0;
        make_ascii  = 8'h00;
        if (strobe_q) begin
            case (state_q)
                NORM: begin
                    if (byte_q == 8'hE0) begin
                        state_d = EXT;
                    end else if (byte_q == 8'hF0) begin
                        state_d = BRK;
                    end else begin
                        last_make_d = byte_q;
                        if (byte_q == 8'h12) begin
                            lshift_d = 1'b1;
                        end else if (byte_q == 8'h59) begin
                            rshift_d = 1'b1;
                        end else if (byte_q == 8'h58) begin
                            // Typematic repeats of Caps Lock must not re-toggle.
                            if (last_make_q != 8'h58) begin
                                caps_d = ~caps_q;
                            end
                        end else begin
                            make_en    = 1'b1;
                            make_ascii = xlate(byte_q, lshift_q | rshift_q, caps_q);
                        end
                    end
                end
                BRK: begin
                    state_d = NORM;
                    if (byte_q == 8'h12) begin
                        lshift_d = 1'b0;
                    end else if (byte_q == 8'h59) begin
                        rshift_d = 1'b0;
                    end
                    if (byte_q == scan_q && pressing_q) begin
                        pressing_d = 1'b0;
                    end
                    // A released key is no longer "previous make" so the
                    // next press of Caps Lock toggles again.
                    if (byte_q == last_make_q) begin
                        last_make_d = 8'h00;
                    end
                end
                EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = NORM;
`ifdef PS2_KBD_NUMPAD_EN
                        if (byte_q == 8'h5A) begin
                            make_en    = 1'b1;
                            make_ascii = 8'h0D;
                        end else if (byte_q == 8'h4A) begin
                            make_en    = 1'b1;
                            make_ascii = 8'h2F;
                        end
`endif
                    end
                end
                EXT_BRK: begin
                    state_d = NORM;
`ifdef PS2_KBD_NUMPAD_EN
                    if ((byte_q == 8'h5A || byte_q == 8'h4A) &&
                        byte_q == scan_q && pressing_q) begin
                        pressing_d = 1'b0;
                    end
`endif
                end
                default: state_d = NORM;
            endcase
        end
        // Unmapped makes (translation 00) leave every output untouched.
        if (make_en && make_ascii != 8'h00) begin
            ascii_d    = make_ascii;
            scan_d     = byte_q;
            pressing_d = 1'b1;
            if (!pressing_q || byte_q != scan_q) begin
                count_d = count_q + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            tmo_q       <= '0;
            strobe_q    <= 1'b0;
            byte_q      <= 8'h00;
            err_q       <= 1'b0;
            state_q     <= NORM;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            last_make_q <= 8'h00;
            pressing_q  <= 1'b0;
            ascii_q     <= 8'h00;
            scan_q      <= 8'h00;
            count_q     <= 8'h00;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            strobe_q    <= strobe_d;
            byte_q      <= byte_d;
            err_q       <= err_d;
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            last_make_q <= last_make_d;
            pressing_q  <= pressing_d;
            ascii_q     <= ascii_d;
            scan_q      <= scan_d;
            count_q     <= count_d;
        end
    end

    assign pressing    = pressing_q;
    assign ascii_write = ascii_q;
    assign scan_code   = scan_q;
    assign shift_o     = lshift_q | rshift_q;
    assign caps_o      = caps_q;
    assign key_count   = count_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_ps2_ascii_kbd.sv
// ---------------------------------------------------------------------------
// tb_ps2_ascii_kbd
//
// Self-checking bench for ps2_ascii_kbd (default build, keypad disabled).
// A table of frames with the expected output state after each one drives
// the main sequence; hand-written sequences cover the idle timeout,
// reset mid-frame and key_count wrap.
// ---------------------------------------------------------------------------
module tb_ps2_ascii_kbd;

    typedef struct {
        logic [7:0] code;
        logic       bad;
        logic       pressing;
        logic [7:0] ascii;
        logic [7:0] scan;
        logic       shift;
        logic       caps;
        logic [7:0] count;
        int         err;
    } vec_t;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       pressing;
    logic [7:0] ascii_write;
    logic [7:0] scan_code;
    logic       shift_o;
    logic       caps_o;
    logic [7:0] key_count;
    logic       frame_err;

    int total;
    int bad;
    int err_pulses;
    int err_base;
    int err_long;
    logic err_prev;
    vec_t sb[$];
    vec_t vecs[41];
    int stepNum;

    ps2_ascii_kbd dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .pressing   (pressing),
        .ascii_write(ascii_write),
        .scan_code  (scan_code),
        .shift_o    (shift_o),
        .caps_o     (caps_o),
        .key_count  (key_count),
        .frame_err  (frame_err)
    );

    // 100 MHz-style system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts frame_err pulses and flags any pulse longer than one cycle
    always @(negedge clk) begin
        if (frame_err) begin
            err_pulses <= err_pulses + 1;
            if (err_prev) err_long <= 1;
        end
        err_prev <= frame_err;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string name, input int actual, input int required);
        total = total + 1;
        if (actual != required) begin
            bad = bad + 1;
            $display("[TB] FAIL %s step=%0d actual=%0h required=%0h", name, stepNum, actual, required);
        end
    endtask

    // Sends the first nbits of a PS/2 frame, half = clk cycles per phase
    task automatic sendBits(input logic [7:0] code, input logic badPar, input int nbits, input int half);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ badPar, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        sb.push_back(v);
        err_base = err_pulses;
        sendBits(v.code, v.bad, 11, 3);
        repeat (15) @(negedge clk);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("pressing", int'(pressing), int'(e.pressing));
            chk("ascii_write", int'(ascii_write), int'(e.ascii));
            chk("scan_code", int'(scan_code), int'(e.scan));
            chk("shift_o", int'(shift_o), int'(e.shift));
            chk("caps_o", int'(caps_o), int'(e.caps));
            chk("key_count", int'(key_count), int'(e.count));
            chk("frame_err_pulses", err_pulses - err_base, e.err);
        end
        stepNum = stepNum + 1;
    endtask

    function automatic vec_t mk(input logic [7:0] c, input logic b, input logic p,
                                input logic [7:0] a, input logic [7:0] s,
                                input logic sh, input logic cp, input logic [7:0] k,
                                input int er);
        vec_t v;
        v.code = c; v.bad = b; v.pressing = p; v.ascii = a; v.scan = s;
        v.shift = sh; v.caps = cp; v.count = k; v.err = er;
        return v;
    endfunction

    initial begin
        vec_t v;
        total = 0; bad = 0; err_pulses = 0; err_base = 0; err_long = 0;
        err_prev = 1'b0; stepNum = 0;
        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;

        //        code   bad  P     ascii  scan   sh   cp   cnt  err
        vecs[0]  = mk(8'h1C, 0, 1, 8'h61, 8'h1C, 0, 0, 8'd1, 0);
        vecs[1]  = mk(8'hF0, 0, 1, 8'h61, 8'h1C, 0, 0, 8'd1, 0);
        vecs[2]  = mk(8'h1C, 0, 0, 8'h61, 8'h1C, 0, 0, 8'd1, 0);
        vecs[3]  = mk(8'h12, 0, 0, 8'h61, 8'h1C, 1, 0, 8'd1, 0);
        vecs[4]  = mk(8'h1C, 0, 1, 8'h41, 8'h1C, 1, 0, 8'd2, 0);
        vecs[5]  = mk(8'hF0, 0, 1, 8'h41, 8'h1C, 1, 0, 8'd2, 0);
        vecs[6]  = mk(8'h1C, 0, 0, 8'h41, 8'h1C, 1, 0, 8'd2, 0);
        vecs[7]  = mk(8'hF0, 0, 0, 8'h41, 8'h1C, 1, 0, 8'd2, 0);
        vecs[8]  = mk(8'h12, 0, 0, 8'h41, 8'h1C, 0, 0, 8'd2, 0);
        vecs[9]  = mk(8'h16, 0, 1, 8'h31, 8'h16, 0, 0, 8'd3, 0);
        vecs[10] = mk(8'h58, 0, 1, 8'h31, 8'h16, 0, 1, 8'd3, 0);
        vecs[11] = mk(8'hF0, 0, 1, 8'h31, 8'h16, 0, 1, 8'd3, 0);
        vecs[12] = mk(8'h58, 0, 1, 8'h31, 8'h16, 0, 1, 8'd3, 0);
        vecs[13] = mk(8'h1C, 0, 1, 8'h41, 8'h1C, 0, 1, 8'd4, 0);
        vecs[14] = mk(8'h16, 0, 1, 8'h31, 8'h16, 0, 1, 8'd5, 0);
        vecs[15] = mk(8'h58, 0, 1, 8'h31, 8'h16, 0, 0, 8'd5, 0);
        vecs[16] = mk(8'h58, 0, 1, 8'h31, 8'h16, 0, 0, 8'd5, 0);
        vecs[17] = mk(8'hF0, 0, 1, 8'h31, 8'h16, 0, 0, 8'd5, 0);
        vecs[18] = mk(8'h58, 0, 1, 8'h31, 8'h16, 0, 0, 8'd5, 0);
        vecs[19] = mk(8'h1C, 0, 1, 8'h61, 8'h1C, 0, 0, 8'd6, 0);
        vecs[20] = mk(8'h1C, 0, 1, 8'h61, 8'h1C, 0, 0, 8'd6, 0);
        vecs[21] = mk(8'h1C, 0, 1, 8'h61, 8'h1C, 0, 0, 8'd6, 0);
        vecs[22] = mk(8'h32, 0, 1, 8'h62, 8'h32, 0, 0, 8'd7, 0);
        vecs[23] = mk(8'h5A, 1, 1, 8'h62, 8'h32, 0, 0, 8'd7, 1);
        vecs[24] = mk(8'h5A, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[25] = mk(8'hE0, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[26] = mk(8'h4A, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[27] = mk(8'hE0, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[28] = mk(8'hF0, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[29] = mk(8'h5A, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[30] = mk(8'h76, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[31] = mk(8'h5A, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[32] = mk(8'hF0, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[33] = mk(8'h5A, 0, 0, 8'h0D, 8'h5A, 0, 0, 8'd8, 0);
        vecs[34] = mk(8'h5A, 0, 1, 8'h0D, 8'h5A, 0, 0, 8'd9, 0);
        vecs[35] = mk(8'h12, 0, 1, 8'h0D, 8'h5A, 1, 0, 8'd9, 0);
        vecs[36] = mk(8'h4E, 0, 1, 8'h5F, 8'h4E, 1, 0, 8'd10, 0);
        vecs[37] = mk(8'hF0, 0, 1, 8'h5F, 8'h4E, 1, 0, 8'd10, 0);
        vecs[38] = mk(8'h12, 0, 1, 8'h5F, 8'h4E, 0, 0, 8'd10, 0);
        vecs[39] = mk(8'h0D, 0, 1, 8'h09, 8'h0D, 0, 0, 8'd11, 0);
        vecs[40] = mk(8'h29, 0, 1, 8'h20, 8'h29, 0, 0, 8'd12, 0);

        // Reset state
        repeat (5) @(negedge clk);
        err_base = err_pulses;
        sb.push_back(mk(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'd0, 0));
        checkOutput();
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        // Main table
        for (int i = 0; i < 41; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Partial frame abandoned by the idle timeout, then a full frame
        $display("[TB] timeout sequence");
        err_base = err_pulses;
        sendBits(8'h66, 0, 5, 3);
        repeat (60000) @(negedge clk);
        v = mk(8'h66, 0, 1, 8'h08, 8'h66, 0, 0, 8'd13, 0);
        sb.push_back(v);
        sendBits(8'h66, 0, 11, 3);
        repeat (15) @(negedge clk);
        checkOutput();

        // Reset pulsed in the middle of a frame
        $display("[TB] reset mid-frame sequence");
        sendBits(8'h66, 0, 5, 3);
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        err_base = err_pulses;
        sb.push_back(mk(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'd0, 0));
        checkOutput();
        applyStimulus(mk(8'h66, 0, 1, 8'h08, 8'h66, 0, 0, 8'd1, 0));
        checkOutput();

        // key_count wrap: alternate codes so each press counts
        $display("[TB] key_count wrap sequence");
        err_base = err_pulses;
        for (int n = 1; n <= 255; n++) begin
            sendBits((n % 2 == 1) ? 8'h32 : 8'h1C, 0, 11, 2);
            if (n == 254) begin
                repeat (15) @(negedge clk);
                sb.push_back(mk(8'h1C, 0, 1, 8'h61, 8'h1C, 0, 0, 8'd255, 0));
                checkOutput();
                err_base = err_pulses;
            end
        end
        repeat (15) @(negedge clk);
        sb.push_back(mk(8'h32, 0, 1, 8'h62, 8'h32, 0, 0, 8'd0, 0));
        checkOutput();

        chk("frame_err_single_cycle", err_long, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
